// File: rtl/icache_refill_arbiter_pkg.sv
// Shared frontend definitions: ICache line geometry, AXI encodings and the refill FSM states.
package icache_refill_arbiter_pkg;

   localparam int ICACHE_ADDR_W     = 32;
   localparam int ICACHE_DATA_W     = 64;
   localparam int ICACHE_LINE_BEATS = 8;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN
   } refillState_t;

   function automatic int lineBytes(input int beats, input int dataW);
      return beats * dataW / 8;
   endfunction

endpackage

// File: rtl/icache_refill_arbiter.sv
// Refill arbiter: picks a demand miss or a prefetch, issues one AXI INCR line burst at a time
// and forwards the returned beats to the requester; a flush drains the burst silently.
module icache_refill_arbiter
   import icache_refill_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ICACHE_ADDR_W,
   parameter int DATA_W     = ICACHE_DATA_W,
   parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic                          i_dmd_valid,
   output logic                          o_dmd_ready,
   input  logic [ADDR_W-1:0]             i_dmd_addr,
   input  logic                          i_pf_valid,
   output logic                          o_pf_ready,
   input  logic [ADDR_W-1:0]             i_pf_addr,
   output logic                          o_rsp_valid,
   output logic                          o_rsp_dst,
   output logic [DATA_W-1:0]             o_rsp_data,
   output logic [$clog2(LINE_BEATS)-1:0] o_rsp_idx,
   output logic                          o_rsp_last,
   output logic                          o_rsp_err,
   output logic                          o_ar_valid,
   input  logic                          i_ar_ready,
   output logic [ADDR_W-1:0]             o_ar_addr,
   output logic [7:0]                    o_ar_len,
   output logic [2:0]                    o_ar_size,
   output logic [1:0]                    o_ar_burst,
   input  logic                          i_r_valid,
   output logic                          o_r_ready,
   input  logic [DATA_W-1:0]             i_r_data,
   input  logic [1:0]                    i_r_resp,
   input  logic                          i_r_last
);

   localparam int                IDX_W      = $clog2(LINE_BEATS);
   localparam int                LINE_BYTES = lineBytes(LINE_BEATS, DATA_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_BEATS - 1);

   refillState_t      r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_dst;
   logic [IDX_W-1:0]  r_cnt;
   logic              r_err;
   logic              r_flushPend;

   logic w_idleOpen;
   logic w_takeDmd;
   logic w_takePf;
   logic w_beat;
   logic w_atLast;
   logic w_term;
   logic w_badResp;

   // Demand beats prefetch; neither is offered a slot while a flush is in progress.
   assign w_idleOpen = (r_state == ST_IDLE) && !i_flush && !i_rst;
   assign w_takeDmd  = w_idleOpen && i_dmd_valid;
   assign w_takePf   = w_idleOpen && !i_dmd_valid && i_pf_valid;

   assign w_beat    = (r_state == ST_DATA) && i_r_valid && !i_rst;
   assign w_atLast  = (r_cnt == LAST_IDX);
   assign w_term    = w_atLast || i_r_last;
   assign w_badResp = (i_r_resp != AXI_RESP_OKAY);

   assign o_dmd_ready = w_idleOpen;
   assign o_pf_ready  = w_idleOpen && !i_dmd_valid;

   assign o_ar_valid = (r_state == ST_ADDR) && !i_rst;
   assign o_ar_addr  = r_addr;
   assign o_ar_len   = 8'(LINE_BEATS - 1);
   assign o_ar_size  = 3'($clog2(DATA_W / 8));
   assign o_ar_burst = AXI_BURST_INCR;

   assign o_r_ready = ((r_state == ST_DATA) || (r_state == ST_DRAIN)) && !i_rst;

   // A burst whose length disagrees with the line size is flagged on its terminating beat.
   assign o_rsp_valid = w_beat && !i_flush;
   assign o_rsp_dst   = r_dst;
   assign o_rsp_data  = i_r_data;
   assign o_rsp_idx   = r_cnt;
   assign o_rsp_last  = o_rsp_valid && w_term;
   assign o_rsp_err   = o_rsp_last && (r_err || w_badResp || (w_atLast != i_r_last));

   // A flush seen while the address is still pending is remembered so the burst is drained.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_dst       <= 1'b0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_flushPend <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_takeDmd || w_takePf) begin
                  r_addr      <= (w_takeDmd ? i_dmd_addr : i_pf_addr) & ALIGN_MASK;
                  r_dst       <= w_takePf;
                  r_err       <= 1'b0;
                  r_flushPend <= 1'b0;
                  r_state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (i_ar_ready) begin
                  r_state     <= (i_flush || r_flushPend) ? ST_DRAIN : ST_DATA;
                  r_cnt       <= '0;
                  r_flushPend <= 1'b0;
               end else if (i_flush) begin
                  r_flushPend <= 1'b1;
               end
            end
            ST_DATA: begin
               if (i_r_valid) begin
                  r_cnt <= r_cnt + IDX_W'(1);
                  if (w_badResp) begin
                     r_err <= 1'b1;
                  end
                  if (w_term) begin
                     r_state <= ST_IDLE;
                  end else if (i_flush) begin
                     r_state <= ST_DRAIN;
                  end
               end else if (i_flush) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_r_valid && i_r_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/icache_refill_arbiter.md
ICACHE_REFILL_ARBITER -- requirements
Module: icache_refill_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, physical address width.
REQ-002 Parameter DATA_W, default 64, AXI read data width.
REQ-003 Parameter LINE_BEATS, default 8, beats per cache line (power of two).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  frontend redirect; kills all in-flight refill traffic.
REQ-007 dmd_valid / dmd_ready / dmd_addr  in / out / in  1 / 1 / ADDR_W  ICache demand-miss request.
REQ-008 pf_valid / pf_ready / pf_addr  in / out / in  1 / 1 / ADDR_W  prefetcher request.
REQ-009 rsp_valid  out  1  one refill beat delivered.
REQ-010 rsp_dst  out  1  0 = demand, 1 = prefetch.
REQ-011 rsp_data / rsp_idx  out  DATA_W / log2(LINE_BEATS)  beat payload and index.
REQ-012 rsp_last / rsp_err  out  1 / 1  final beat; line had any non-OKAY response.
REQ-013 ar_valid / ar_ready / ar_addr / ar_len / ar_size / ar_burst  out / in / out / out / out / out  1 / 1 / ADDR_W / 8 / 3 / 2  AXI read address channel.
REQ-014 r_valid / r_ready / r_data / r_resp / r_last  in / out / in / in / in  1 / 1 / DATA_W / 2 / 1  AXI read data channel.

Function
REQ-015 States IDLE, ADDR, DATA, DRAIN; exactly one AXI transaction outstanding at any time.
REQ-016 IDLE: dmd_valid has fixed priority over pf_valid; the winner sees its ready=1 in the same cycle; the request is accepted on valid&ready.
REQ-017 Ready outputs are 1 only in IDLE with flush=0; a request presented while flush=1 is not accepted.
REQ-018 On acceptance, latch address aligned down to line size, latch rsp_dst, go to ADDR; ar_valid rises the next cycle.
REQ-019 ADDR: ar_valid=1 with ar_addr, ar_len=LINE_BEATS-1, ar_size=log2(DATA_W/8), ar_burst=INCR; all held stable until ar_ready.
REQ-020 ADDR with flush (this cycle or pending): ar_valid is never retracted; after the AR handshake go to DRAIN instead of DATA.
REQ-021 ADDR, no flush, ar_ready=1: go to DATA, beat counter cleared to 0.
REQ-022 DATA and DRAIN: r_ready=1 unconditionally.
REQ-023 DATA: each r_valid beat produces rsp_valid=1 in the same cycle (combinational forward), rsp_idx=counter, rsp_data=r_data; counter increments modulo LINE_BEATS.
REQ-024 rsp_err is sticky per line: set by any beat with r_resp!=OKAY, reported with the last beat, cleared on new acceptance.
REQ-025 rsp_last=1 when counter==LINE_BEATS-1 or r_last=1; that beat returns the FSM to IDLE; a new request can be accepted the cycle after.
REQ-026 Counter reaching LINE_BEATS-1 without r_last, or r_last early: terminate on whichever comes first, force rsp_err=1 on that beat.
REQ-027 flush=1 in DATA: the same-cycle beat is suppressed (rsp_valid=0); go to DRAIN.
REQ-028 DRAIN: consume beats with rsp_valid=0 until r_last, then IDLE.
REQ-029 flush in IDLE or DRAIN: no state effect beyond REQ-017.

Reset
REQ-030 rst=1: state IDLE, counter 0, sticky error 0, flush-pending 0; ar_valid, r_ready, rsp_valid, dmd_ready, pf_ready all 0 in the cycle rst is high.
REQ-031 Reset mid-transaction abandons it; outstanding AXI beats are the interconnect's responsibility (reset domain shared).

Structure
REQ-032 The state enum, AXI burst/resp encodings and line-geometry constants live in the shared frontend package alongside the ICache line parameters.
REQ-033 Single module; request selection is a 2-way fixed-priority arbiter inline, no sub-module.

Verification
REQ-034 dmd and pf both valid at 0x8000_0044 / 0x8000_1000 -> demand granted, ar_addr=0x8000_0040, ar_len=7; pf granted only after demand rsp_last.
REQ-035 ar_ready held low 5 cycles -> ar_valid and ar_addr stable all 5 cycles; 8 beats delivered rsp_idx 0..7, rsp_last only on idx 7.
REQ-036 flush on beat 3 of prefetch refill -> rsp_valid 0 from beat 3 onward, all 8 beats consumed, IDLE after r_last, next request accepted next cycle.
REQ-037 flush while ar_valid=1, ar_ready=0 -> ar_valid stays 1 until handshake, all 8 beats drained, zero rsp_valid.
REQ-038 r_resp=SLVERR on beat 2 -> rsp_err=1 with beat 7; next line's rsp_err=0.
REQ-039 rst asserted during DATA -> next cycle IDLE, all valid/ready outputs 0.
